// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts per key size,
// the round-counter state type and the GF(2^8) xtime helper used for rcon.
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128  = 2'b00,
        KEY_192  = 2'b01,
        KEY_256  = 2'b10,
        KEY_RSVD = 2'b11
    } key_len_e;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rc_state_e;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Final round index for a key size; the reserved code behaves as 128-bit.
    function automatic logic [3:0] nr_for_key(input key_len_e kl);
        logic [3:0] nr;
        case (kl)
            KEY_192: nr = 4'(NR_192);
            KEY_256: nr = 4'(NR_256);
            default: nr = 4'(NR_128);
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_counter.sv
// AES round sequencer: tracks the round index and round constant of one block,
// advancing once per datapath strobe and flagging the first and final rounds.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter  int NR_MAX = 14,
    localparam int RW     = $clog2(NR_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_dp_en,
    input  logic [1:0]    i_key_len,
    output logic          o_active,
    output logic [RW-1:0] o_round,
    output logic          o_first,
    output logic          o_last,
    output logic [7:0]    o_rcon,
    output logic          o_done
);

    rc_state_e     state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [RW-1:0] nr_q,    nr_d;
    logic [7:0]    rcon_q,  rcon_d;
    logic          done_q,  done_d;

    // State register; reset returns to the idle/round-0 view with 128-bit Nr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            nr_q    <= RW'(NR_128);
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: start only from idle, advance on strobe, finish after round Nr.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    nr_d    = RW'(nr_for_key(key_len_e'(i_key_len)));
                    round_d = '0;
                    rcon_d  = 8'h01;
                end
            end
            ST_RUN: begin
                if (i_dp_en) begin
                    if (round_q < nr_q) begin
                        round_d = round_q + RW'(1);
                        // Rounds 0 and 1 share rcon 0x01; afterwards it doubles.
                        if (round_q != '0) begin
                            rcon_d = xtime(rcon_q);
                        end
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        round_d = '0;
                        rcon_d  = 8'h01;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, free of input paths.
    always_comb begin
        o_active = (state_q == ST_RUN);
        o_round  = round_q;
        o_rcon   = rcon_q;
        o_done   = done_q;
        o_first  = o_active && (round_q == '0);
        o_last   = o_active && (round_q == nr_q);
    end

endmodule

// File: doc/aes_round_counter.md
AES_ROUND_COUNTER -- requirements
Module: aes_round_counter

Interface
REQ-001 Parameter NR_MAX, default 14: maximum round count supported; sets the o_round width of 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  block-start pulse from the AES control unit; sampled only when idle.
REQ-005 i_dp_en  input  1  datapath-advance strobe (control unit o_dp_en); one round per cycle asserted.
REQ-006 i_key_len  input  2  key size: 00=128, 01=192, 10=256, 11=reserved (treated as 128); latched at start.
REQ-007 o_active  output  1  block in progress.
REQ-008 o_round  output  4  current round index, 0..Nr.
REQ-009 o_first  output  1  high while active and round==0 (initial AddRoundKey).
REQ-010 o_last  output  1  high while active and round==Nr (no MixColumns); drives control unit i_flag.
REQ-011 o_rcon  output  8  round constant for current round.
REQ-012 o_done  output  1  one-cycle pulse on completion of the final round.

Function
REQ-013 Two states SHALL exist: IDLE and RUN.
REQ-014 IDLE with i_start=1 SHALL latch Nr (10/12/14 per i_key_len) and move to RUN with round=0 and rcon=0x01 on the next edge; the start-to-round-0 latency is 1 cycle.
REQ-015 In RUN with i_dp_en=0, round, rcon and flags SHALL hold (stall).
REQ-016 In RUN with i_dp_en=1 and round<Nr, round SHALL increment by 1.
REQ-017 On that same advance, rcon SHALL hold when moving 0->1 and otherwise become xtime(rcon): shift left 1, XOR 0x1B if bit7 was set.
REQ-018 The resulting o_rcon sequence SHALL be r1..r14 = 01,02,04,08,10,20,40,80,1B,36,6C,D8,AB,4D.
REQ-019 In RUN with i_dp_en=1 and round==Nr, the block SHALL return to IDLE, assert o_done for exactly one cycle, and set round=0 and rcon=0x01.
REQ-020 o_first and o_last SHALL be decoded from registered state only, with no combinational path from inputs.
REQ-021 i_start in RUN SHALL be ignored; i_key_len changes in RUN SHALL be ignored.
REQ-022 i_start coincident with the final advance SHALL be ignored, so completion wins; the control unit reissues start.
REQ-023 i_dp_en in IDLE SHALL have no effect.
REQ-024 round SHALL never exceed Nr, with no wrap-around; i_key_len=11 SHALL behave exactly as 00.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, o_active=0, o_round=0, o_first=0, o_last=0, o_rcon=0x01, o_done=0, and latched Nr=10.
REQ-026 Reset mid-block SHALL abort without an o_done pulse, and rst SHALL take priority over i_start and i_dp_en.

Structure
REQ-027 The shared package aes_pkg SHALL hold the key-length encodings, the NR_128/NR_192/NR_256 constants (10/12/14) and the xtime function.
REQ-028 There SHALL be no sub-module; the rcon update is the aes_pkg xtime function, inlined.

Verification
REQ-029 Scenario: rst high 3 cycles with random inputs -> all outputs at reset values; no o_done.
REQ-030 Scenario: key_len=00, i_start pulse, i_dp_en held 1 -> o_first on cycle 1, o_round 0..10, and o_last together with o_rcon=0x36 on cycle 11. Then o_done on cycle 12 and o_active=0 after.
REQ-031 Scenario: key_len=10, i_dp_en held 1 -> o_last at round 14 with o_rcon=0x4D; key_len=01 -> o_last at round 12 with o_rcon=0xD8.
REQ-032 Scenario: key_len=00, i_dp_en toggled 1/0 -> each round holds 2 cycles; o_done is 21 cycles after start is registered.
REQ-033 Scenario: i_start and key_len=10 pulsed at round 4 of a 128-bit block -> still ends at round 10; start coincident with the final advance -> no new block.
REQ-034 Scenario: rst asserted at round 5 -> next cycle o_round=0, o_active=0, no o_done.
REQ-035 Scenario: key_len=11 -> identical trace to key_len=00.
